// File: rtl/lane_gather_pkg.sv
// Shared types for the lane gatherer: lane/word shapes and the FSM encoding.
// No logic; pure type and constant definitions.
// Backpressure: n/a.
package lane_gather_pkg;

  localparam int LANE_W_DEF = 5;
  localparam int LANES_DEF  = 16;

  typedef logic [LANE_W_DEF-1:0] lane_t;

  // Multi-dimensional view the consumer stage takes; 2*2*4*5 = 80 bits, so a
  // flat cast from LANES_DEF lanes of LANE_W_DEF bits maps lane 0 to the LSBs.
  typedef logic [3:2][3:4][1:4][0:4] word80_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fsm_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
// Latency: count visible the cycle after inc is sampled.
// Backpressure: none; inc is ignored once saturated.
//   clk   : clock
//   rst_n : synchronous active-low reset, clears the count
//   inc   : increment request
//   cnt   : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/lane_gather80.sv
// Gathers 5-bit lane beats into an 80-bit packed word, short words via in_last.
// Latency: word valid the cycle after its closing beat; one beat/cycle sustained.
// Backpressure: while a word is held, in_ready follows out_ready.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input beat handshake; in_data payload, in_last closes word
//   out_valid/out_ready : output word handshake; out_word lanes, out_len lane count
//   out_par             : XOR of out_word
//   word_cnt            : retired words, saturating
module lane_gather80
  import lane_gather_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int LANES  = LANES_DEF,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W*LANES-1:0] out_word,
  output logic [4:0]              out_len,
  output logic                    out_par,
  output logic [CNT_W-1:0]        word_cnt
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

  fsm_t                         state_q, state_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [LANES-1:0][LANE_W-1:0] lanes_q, lanes_d;
  logic [4:0]                   len_q, len_d;
  logic                         retire;
  word80_t                      word_view;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lanes_d   = lanes_q;
    len_d     = len_q;
    retire    = 1'b0;
    in_ready  = 1'b1;
    out_valid = 1'b0;

    case (state_q)
      FILL: begin
        // in_data/in_last are only looked at under in_valid, so X on an idle
        // bus never reaches the registers.
        if (in_valid) begin
          lanes_d[idx_q] = in_data;
          if ((idx_q == IDX_LAST) || in_last) begin
            len_d   = 5'(idx_q) + 5'd1;
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      FULL: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          retire  = 1'b1;
          // Clearing on retire is what makes unwritten lanes of the next
          // word read as zero.
          lanes_d = '0;
          len_d   = '0;
          idx_d   = '0;
          state_d = FILL;
          if (in_valid) begin
            lanes_d[0] = in_data;
            if (in_last) begin
              len_d   = 5'd1;
              state_d = FULL;
            end else begin
              idx_d = IDX_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      len_q   <= len_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .cnt   (word_cnt)
  );

  // Route through the consumer's word shape so the flat layout is pinned.
  assign word_view = word80_t'(lanes_q);
  assign out_word  = word_view;
  assign out_len   = len_q;
  assign out_par   = ^out_word;

endmodule

// File: tb/tb_lane_gather80.sv
module tb_lane_gather80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_data = 5'd0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [79:0] out_word;
  logic [4:0]  out_len;
  logic        out_par;
  logic [7:0]  word_cnt;

  // Second instance with a 2-bit counter, sharing all inputs.
  logic        in_ready2;
  logic        out_valid2;
  logic [79:0] out_word2;
  logic [4:0]  out_len2;
  logic        out_par2;
  logic [1:0]  word_cnt2;

  int tests_run = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lane_gather80 #(.LANE_W(5), .LANES(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_len(out_len),
    .out_par(out_par), .word_cnt(word_cnt)
  );

  lane_gather80 #(.LANE_W(5), .LANES(16), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
    .out_ready(out_ready), .out_word(out_word2), .out_len(out_len2),
    .out_par(out_par2), .word_cnt(word_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_data  = 5'bxxxxx;
    in_last  = 1'bx;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests_run++;
    if (out_word !== 80'd0) begin fails++; $display("FAIL reset_word got %h want 0", out_word); end
    tests_run++;
    if (out_len !== 5'd0) begin fails++; $display("FAIL reset_len got %0d want 0", out_len); end
    tests_run++;
    if (word_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", word_cnt); end
    tests_run++;
    if (out_par !== 1'b0) begin fails++; $display("FAIL reset_par got %b want 0", out_par); end
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_full_word();
    logic [79:0] exp;
    exp = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL full_early_valid lane %0d got %b want 0", k, out_valid); end
      beat(5'(k), 1'b0);
      exp[5*k +: 5] = 5'(k);
    end
    tests_run++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL full_valid got %b want 1", out_valid); end
    tests_run++;
    if (out_word !== exp) begin fails++; $display("FAIL full_word got %h want %h", out_word, exp); end
    tests_run++;
    if (out_len !== 5'd16) begin fails++; $display("FAIL full_len got %0d want 16", out_len); end
    tests_run++;
    if (out_par !== 1'b0) begin fails++; $display("FAIL full_par got %b want 0", out_par); end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL full_in_ready got %b want 1", in_ready); end
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (word_cnt !== 8'd1) begin fails++; $display("FAIL full_cnt got %0d want 1", word_cnt); end
    tests_run++;
    if (out_valid !== 1'b0 || out_word !== 80'd0 || out_len !== 5'd0) begin
      fails++; $display("FAIL full_clear got v=%b w=%h l=%0d want 0/0/0", out_valid, out_word, out_len);
    end
  endtask

  task automatic test_short_word();
    // lanes 0..2 = 1F, 0A, 11 -> 0x11<<10 | 0x0A<<5 | 0x1F
    beat(5'h1F, 1'b0);
    beat(5'h0A, 1'b0);
    beat(5'h11, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1) begin fails++; $display("FAIL short_valid got %b want 1", out_valid); end
    tests_run++;
    if (out_len !== 5'd3) begin fails++; $display("FAIL short_len got %0d want 3", out_len); end
    tests_run++;
    if (out_word !== 80'h455F) begin fails++; $display("FAIL short_word got %h want 455f", out_word); end
    tests_run++;
    if (out_par !== 1'b1) begin fails++; $display("FAIL short_par got %b want 1", out_par); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 5'h1C;
    in_last   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc %0d got %b want 0", c, in_ready); end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_word !== 80'h455F || out_len !== 5'd3) begin
        fails++; $display("FAIL bp_hold cyc %0d got v=%b w=%h l=%0d want 1/455f/3", c, out_valid, out_word, out_len);
      end
    end
    out_ready = 1'b1;
    in_data   = 5'h07;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tests_run++;
    if (word_cnt !== 8'd2) begin fails++; $display("FAIL bp_cnt got %0d want 2", word_cnt); end
    tests_run++;
    if (out_valid !== 1'b0 || out_word !== 80'h7) begin
      fails++; $display("FAIL bp_overlap got v=%b w=%h want 0/7", out_valid, out_word);
    end
    beat(5'h02, 1'b1);
    tests_run++;
    if (out_word !== 80'h47 || out_len !== 5'd2) begin
      fails++; $display("FAIL bp_next_word got w=%h l=%0d want 47/2", out_word, out_len);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (word_cnt !== 8'd3) begin fails++; $display("FAIL bp_cnt2 got %0d want 3", word_cnt); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 5'(k + 1);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready beat %0d got %b want 1", k, in_ready); end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_len !== 5'd1 || out_word !== 80'(k + 1)) begin
        fails++; $display("FAIL b2b_word beat %0d got v=%b l=%0d w=%h want 1/1/%0h", k, out_valid, out_len, out_word, k + 1);
      end
      tests_run++;
      if (word_cnt !== 8'(3 + k)) begin fails++; $display("FAIL b2b_cnt beat %0d got %0d want %0d", k, word_cnt, 3 + k); end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (word_cnt !== 8'd9 || out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_drain got cnt=%0d v=%b want 9/0", word_cnt, out_valid);
    end
  endtask

  task automatic test_reset_midfill();
    logic [79:0] exp;
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) beat(5'h15, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || word_cnt !== 8'd0 || out_word !== 80'd0) begin
      fails++; $display("FAIL rst_mid_state got v=%b cnt=%0d w=%h want 0/0/0", out_valid, word_cnt, out_word);
    end
    exp = '0;
    for (int k = 0; k < 16; k++) begin
      beat(5'((k + 3) % 32), 1'b0);
      exp[5*k +: 5] = 5'((k + 3) % 32);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_len !== 5'd16 || out_word !== exp) begin
      fails++; $display("FAIL rst_mid_word got v=%b l=%0d w=%h want 1/16/%h", out_valid, out_len, out_word, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests_run++;
    if (word_cnt !== 8'd1) begin fails++; $display("FAIL rst_mid_cnt got %0d want 1", word_cnt); end
  endtask

  task automatic test_saturation();
    int exp_sat;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = 5'h09;
    // Tick 0 loads the first word; each later tick retires one.
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      tick();
      exp_sat = (i > 3) ? 3 : i;
      tests_run++;
      if (word_cnt2 !== 2'(exp_sat)) begin fails++; $display("FAIL sat_cnt2 step %0d got %0d want %0d", i, word_cnt2, exp_sat); end
      tests_run++;
      if (word_cnt !== 8'(i)) begin fails++; $display("FAIL sat_cnt8 step %0d got %0d want %0d", i, word_cnt, i); end
    end
    out_ready = 1'b0;
    tests_run++;
    if (out_valid2 !== 1'b0) begin fails++; $display("FAIL sat_valid2 got %b want 0", out_valid2); end
  endtask

  initial begin
    in_data = 5'bxxxxx;
    in_last = 1'bx;
    test_reset();
    test_full_word();
    test_short_word();
    test_backpressure();
    test_back_to_back();
    test_reset_midfill();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
